// File: rtl/execute_stage_if.sv
// ALU opcode type and the interface between the execute stage (front) and the ALU (back).
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHIFT_L,
        ALU_SHIFT_R,
        ALU_SHIFT_R_ARITH,
        ALU_LESS_THAN,
        ALU_LESS_THAN_UNSIGNED
    } alu_operation;
endpackage

interface executor_to_alu;
    import alu_pkg::*;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  result;
    alu_operation operation;

    modport front (output a, output b, output operation, input result);
    modport back  (input a, input b, input operation, output result);
endinterface

// File: rtl/execute_stage.sv
// Single-entry execute pipeline stage with result forwarding, plus the combinational ALU it drives.
module alu
    import alu_pkg::*;
(
    executor_to_alu.back bus
);
    always_comb begin
        bus.result = 32'd0;
        case (bus.operation)
            ALU_ADD:                bus.result = bus.a + bus.b;
            ALU_SUB:                bus.result = bus.a - bus.b;
            ALU_AND:                bus.result = bus.a & bus.b;
            ALU_OR:                 bus.result = bus.a | bus.b;
            ALU_XOR:                bus.result = bus.a ^ bus.b;
            ALU_SHIFT_L:            bus.result = bus.a << bus.b[4:0];
            ALU_SHIFT_R:            bus.result = bus.a >> bus.b[4:0];
            ALU_SHIFT_R_ARITH:      bus.result = $unsigned($signed(bus.a) >>> bus.b[4:0]);
            ALU_LESS_THAN:          bus.result = {31'd0, $signed(bus.a) < $signed(bus.b)};
            ALU_LESS_THAN_UNSIGNED: bus.result = {31'd0, bus.a < bus.b};
            default:                bus.result = 32'd0;
        endcase
    end
endmodule

module execute_stage
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  alu_operation in_op,
    input  logic [3:0]   in_rs1,
    input  logic [3:0]   in_rs2,
    input  logic [31:0]  in_rs1_val,
    input  logic [31:0]  in_rs2_val,
    input  logic [31:0]  in_imm,
    input  logic         in_use_imm,
    input  logic [3:0]   in_rd,
    executor_to_alu.front alu,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_rd,
    output logic [31:0]  out_result,
    output logic         out_write_en,
    output logic [31:0]  retired
);
    logic accept;
    logic fwd1;
    logic fwd2;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Forward from the held result even when it is being consumed this cycle; x0 is never forwarded.
    assign fwd1 = out_valid && out_write_en && (out_rd == in_rs1) && (in_rs1 != 4'd0);
    assign fwd2 = out_valid && out_write_en && (out_rd == in_rs2) && (in_rs2 != 4'd0);

    assign op_a = fwd1 ? out_result : in_rs1_val;
    assign op_b = in_use_imm ? in_imm : (fwd2 ? out_result : in_rs2_val);

    assign alu.a         = op_a;
    assign alu.b         = op_b;
    assign alu.operation = in_valid ? in_op : ALU_NONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_write_en <= 1'b0;
            out_rd       <= 4'd0;
            out_result   <= 32'd0;
            retired      <= 32'd0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_result   <= alu.result;
            out_rd       <= in_rd;
            out_write_en <= (in_rd != 4'd0) && (in_op != ALU_NONE);
            retired      <= retired + 32'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expectations, a monitor pops on each consume.
module tb_execute_stage;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    alu_operation in_op;
    logic [3:0]   in_rs1, in_rs2, in_rd;
    logic [31:0]  in_rs1_val, in_rs2_val, in_imm;
    logic         in_use_imm;
    logic         out_valid, out_ready, out_write_en;
    logic [3:0]   out_rd;
    logic [31:0]  out_result, retired;

    always #5 clk = ~clk;

    executor_to_alu alu_bus ();
    alu u_alu (.bus(alu_bus.back));

    execute_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
        .alu(alu_bus.front),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_write_en(out_write_en), .retired(retired)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] result;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed output is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got rd=%0d result=%h, want no output", out_rd, out_result);
            end else begin
                e = sb.pop_front();
                check("sb_result", out_result, e.result);
                check("sb_rd", 32'(out_rd), 32'(e.rd));
                check("sb_we", 32'(out_write_en), 32'(e.we));
            end
        end
    end

    task automatic set_op(input alu_operation op, input logic [3:0] rs1, input logic [31:0] v1,
                          input logic [3:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                          input logic ui, input logic [3:0] rd);
        in_op = op; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2; in_rs2_val = v2;
        in_imm = imm; in_use_imm = ui; in_rd = rd; in_valid = 1'b1;
    endtask

    task automatic issue(input alu_operation op, input logic [3:0] rs1, input logic [31:0] v1,
                         input logic [3:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                         input logic ui, input logic [3:0] rd, input logic [31:0] exp, input logic we);
        int n;
        set_op(op, rs1, v1, rs2, v2, imm, ui, rd);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, want 1", n);
        end else begin
            sb.push_back('{rd: rd, result: exp, we: we});
            exp_ret = exp_ret + 32'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        set_op(ALU_ADD, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd9);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_we", 32'(out_write_en), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_retired", retired, 32'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic immediate add, one-cycle latency.
        out_ready = 1'b1;
        issue(ALU_ADD, 4'd1, 32'd5, 4'd2, 32'd0, 32'd7, 1'b1, 4'd3, 32'd12, 1'b1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_result", out_result, 32'd12);
        check("lat_out_rd", 32'(out_rd), 32'd3);
        check("lat_out_we", 32'(out_write_en), 32'd1);
        check("lat_retired", retired, 32'd1);

        // Forwarding chain under continuous flow.
        issue(ALU_ADD, 4'd0, 32'd0, 4'd0, 32'd0, 32'd10, 1'b1, 4'd1, 32'd10, 1'b1);
        issue(ALU_SUB, 4'd1, 32'd99, 4'd1, 32'd99, 32'd0, 1'b0, 4'd2, 32'd0, 1'b1);
        issue(ALU_ADD, 4'd2, 32'd99, 4'd1, 32'd99, 32'd0, 1'b0, 4'd3, 32'd99, 1'b1);
        issue(ALU_ADD, 4'd5, 32'd7, 4'd3, 32'd1000, 32'd0, 1'b0, 4'd4, 32'd106, 1'b1);
        issue(ALU_ADD, 4'd0, 32'd0, 4'd0, 32'd0, 32'd1, 1'b1, 4'd0, 32'd1, 1'b0);
        issue(ALU_ADD, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd6, 32'd0, 1'b1);
        issue(ALU_ADD, 4'd8, 32'd1, 4'd0, 32'd0, 32'd5, 1'b1, 4'd9, 32'd6, 1'b1);
        issue(ALU_ADD, 4'd0, 32'd0, 4'd9, 32'd77, 32'd2, 1'b1, 4'd10, 32'd2, 1'b1);

        // ALU operations and write-enable suppression.
        issue(ALU_SHIFT_R_ARITH, 4'd8, 32'h8000_0000, 4'd9, 32'd4, 32'd0, 1'b0, 4'd11, 32'hF800_0000, 1'b1);
        issue(ALU_SHIFT_R, 4'd8, 32'h8000_0000, 4'd9, 32'd4, 32'd0, 1'b0, 4'd12, 32'h0800_0000, 1'b1);
        issue(ALU_LESS_THAN_UNSIGNED, 4'd8, 32'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd13, 32'd1, 1'b1);
        issue(ALU_LESS_THAN, 4'd8, 32'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd14, 32'd0, 1'b1);
        issue(ALU_SUB, 4'd8, 32'd3, 4'd9, 32'd5, 32'd0, 1'b0, 4'd11, 32'hFFFF_FFFE, 1'b1);
        issue(ALU_XOR, 4'd8, 32'hFF00_FF00, 4'd9, 32'h0FF0_0FF0, 32'd0, 1'b0, 4'd12, 32'hF0F0_F0F0, 1'b1);
        issue(ALU_AND, 4'd8, 32'h0000_F0F0, 4'd9, 32'h0000_FF00, 32'd0, 1'b0, 4'd13, 32'h0000_F000, 1'b1);
        issue(ALU_SHIFT_L, 4'd8, 32'd1, 4'd9, 32'd31, 32'd0, 1'b0, 4'd14, 32'h8000_0000, 1'b1);
        issue(ALU_NONE, 4'd8, 32'd3, 4'd9, 32'd4, 32'd0, 1'b0, 4'd5, 32'd0, 1'b0);
        issue(ALU_OR, 4'd8, 32'h55, 4'd9, 32'd0, 32'hAA, 1'b1, 4'd0, 32'hFF, 1'b0);
        issue(ALU_ADD, 4'd8, 32'd100, 4'd9, 32'd999, 32'hFFFF_FFFF, 1'b1, 4'd11, 32'd99, 1'b1);

        // Drain, then confirm idle inputs change nothing.
        repeat (2) @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        set_op(ALU_ADD, 4'd1, 32'd1, 4'd1, 32'd1, 32'd1, 1'b1, 4'd7);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_retired", retired, exp_ret);

        // Backpressure: hold result for 3 cycles, then consume and accept together.
        out_ready = 1'b0;
        issue(ALU_AND, 4'd8, 32'hF0, 4'd9, 32'h3C, 32'd0, 1'b0, 4'd6, 32'h30, 1'b1);
        set_op(ALU_SHIFT_L, 4'd1, 32'd1, 4'd0, 32'd0, 32'd4, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_result", out_result, 32'h30);
            check("stall_out_rd", 32'(out_rd), 32'd6);
            check("stall_retired", retired, exp_ret);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_in_ready", 32'(in_ready), 32'd1);
        sb.push_back('{rd: 4'd7, result: 32'd16, we: 1'b1});
        exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("resume_out_valid", 32'(out_valid), 32'd1);
        check("resume_out_result", out_result, 32'd16);
        check("resume_retired", retired, exp_ret);

        // Retired counter wraps on accept.
        @(negedge clk);
        force dut.retired = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.retired;
        exp_ret = 32'hFFFF_FFFF;
        issue(ALU_ADD, 4'd8, 32'd2, 4'd9, 32'd3, 32'd0, 1'b0, 4'd12, 32'd5, 1'b1);
        check("wrap_retired", retired, 32'd0);

        // Reset mid-stream discards the held operation.
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(ALU_ADD, 4'd8, 32'd2, 4'd9, 32'd2, 32'd0, 1'b0, 4'd13, 32'd4, 1'b1);
        force dut.retired = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.retired;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_retired", retired, 32'd0);
        check("mid_rst_out_we", 32'(out_write_en), 32'd0);
        check("mid_rst_out_result", out_result, 32'd0);
        sb.delete();
        exp_ret = 32'd0;
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        issue(ALU_OR, 4'd8, 32'h0F, 4'd9, 32'hF0, 32'd0, 1'b0, 4'd14, 32'hFF, 1'b1);
        check("post_rst_retired", retired, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on clk rising edge.
REQ-003 SHALL have port in_valid, input, 1, the decoded operation on in_* is present.
REQ-004 SHALL have port in_ready, output, 1, the stage accepts in_* this cycle.
REQ-005 SHALL have port in_op, input, alu_operation, ALU operation code (ALU_NONE..ALU_LESS_THAN_UNSIGNED).
REQ-006 SHALL have ports in_rs1 and in_rs2, input, 4 each, source register indices (RV32E x0..x15).
REQ-007 SHALL have ports in_rs1_val and in_rs2_val, input, 32 each, register-file read values.
REQ-008 SHALL have port in_imm, input, 32, sign-extended immediate.
REQ-009 SHALL have port in_use_imm, input, 1, selects in_imm instead of operand 2.
REQ-010 SHALL have port in_rd, input, 4, destination register index.
REQ-011 SHALL have port alu, executor_to_alu.front, -, drives a/b/operation and reads result combinationally.
REQ-012 SHALL have port out_valid, output, 1, out_* holds a completed result.
REQ-013 SHALL have port out_ready, input, 1, downstream (writeback) consumes out_* this cycle.
REQ-014 SHALL have ports out_rd (output, 4) and out_result (output, 32), destination index and registered ALU result.
REQ-015 SHALL have port out_write_en, output, 1, result is to be written to the register file.
REQ-016 SHALL have port retired, output, 32, count of operations accepted since reset.

Function
REQ-017 SHALL drive in_ready = !out_valid || out_ready (single-entry pipeline register, no bubble under continuous flow).
REQ-018 SHALL define accept = in_valid && in_ready.
REQ-019 SHALL form operand A as fwd1 ? out_result : in_rs1_val, where fwd1 = out_valid && out_write_en && out_rd == in_rs1 && in_rs1 != 0.
REQ-020 SHALL form operand B as in_imm when in_use_imm=1; otherwise fwd2 ? out_result : in_rs2_val, with fwd2 defined as fwd1 using in_rs2.
REQ-021 SHALL drive alu.a = operand A, alu.b = operand B, and alu.operation = in_op when in_valid=1, else ALU_NONE.
REQ-022 SHALL, on accept, register out_result <= alu.result, out_rd <= in_rd, out_write_en <= (in_rd != 0 && in_op != ALU_NONE), and out_valid <= 1; latency is exactly 1 cycle.
REQ-023 SHALL, on out_valid && out_ready without accept, clear out_valid to 0 and hold out_rd/out_result/out_write_en.
REQ-024 SHALL hold all out_* stable while out_valid=1 and out_ready=0 (no overwrite, in_ready=0).
REQ-025 SHALL, on simultaneous consume and accept, load the new operation so that out_valid stays 1.
REQ-026 SHALL forward from out_result when fwd1/fwd2 holds, including when that result is being consumed in the same cycle.
REQ-027 SHALL increment retired by 1 on each accept, wrapping modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-028 SHALL ignore in_* values when in_valid=0; no state other than the consume path changes.

Reset
REQ-029 SHALL, while reset=1, set out_valid=0, out_write_en=0, out_rd=0, out_result=0, and retired=0, taking precedence over accept and consume.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset deasserts, and SHALL discard any operation held when reset is asserted mid-stream.

Verification
REQ-031 Stimulus: ALU_ADD with rs1_val=5, imm=7, use_imm=1, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=12, out_rd=3, out_write_en=1, retired=1.
REQ-032 Stimulus: back-to-back x1=x0+10 (ADD imm), then x2=x1-x1 (SUB) with stale rs1_val=rs2_val=99 -> second result 0 via forwarding; rs1=0 with out_rd=0 is never forwarded.
REQ-033 Stimulus: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged, retired unchanged; on out_ready=1 the held result is consumed and the next operation is accepted in the same cycle.
REQ-034 Stimulus: rd=0 ALU_OR, and any ALU_NONE -> out_valid=1, out_write_en=0.
REQ-035 Stimulus: ALU_SHIFT_R_ARITH a=0x80000000, b=4 -> 0xF8000000; ALU_LESS_THAN_UNSIGNED a=1, b=0xFFFFFFFF -> 1; ALU_LESS_THAN with the same operands -> 0.
REQ-036 Stimulus: reset asserted while out_valid=1 and retired=0xFFFFFFFF -> next cycle out_valid=0 and retired=0; separately, accept at 0xFFFFFFFF -> retired wraps to 0.
